sensor_conditioner: RTL and testbench

- Upstream front end of `TrafficLightController`; sits between the raw roadside sensors and the controller's `IR_sensors` / `sound_sensors` inputs.
- Synchronises and debounces the 12 IR vehicle sensors.
- Confirms and latches siren detections into a single priority-resolved, held emergency channel.
- Publishes a per-road 2-bit occupancy count for status and debug.

---
 rtl/sensor_conditioner.sv | 187 ++++++++++++++++++
 tb/tb_sensor_conditioner.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_conditioner.sv
// Roadside sensor front end: synchronises and debounces the IR vehicle sensors, confirms and
// holds a single priority-resolved siren channel, and publishes per-road occupancy counts.
module sensor_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned SND_CONFIRM     = 8,
    parameter int unsigned SND_HOLD        = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] raw_ir,
    input  logic [3:0]  raw_sound,
    output logic [11:0] IR_sensors,
    output logic [3:0]  sound_sensors,
    output logic [7:0]  density,
    output logic        emergency_active
);

    localparam int unsigned IR_W  = 12;
    localparam int unsigned SND_W = 4;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned DEN_W = 8;

    localparam logic [CNT_W-1:0] DEB_LIM  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CONF_LIM = CNT_W'(SND_CONFIRM);
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(SND_HOLD);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONFIRM = 2'd1,
        S_ACTIVE  = 2'd2,
        S_HOLD    = 2'd3
    } snd_state_e;

    logic [IR_W-1:0]  ir_meta_q, s_ir_q;
    logic [SND_W-1:0] snd_meta_q, s_snd_q;

    logic [IR_W-1:0]  ir_q, ir_d;
    logic [CNT_W-1:0] db_cnt_q [IR_W];
    logic [CNT_W-1:0] db_cnt_d [IR_W];
    logic [DEN_W-1:0] density_q, density_d;

    snd_state_e       state_q, state_d;
    logic [1:0]       cand_q, cand_d;
    logic [CNT_W-1:0] snd_cnt_q, snd_cnt_d;
    logic [SND_W-1:0] snd_q, snd_d;
    logic             emerg_q, emerg_d;

    // Highest-priority pending siren: bit 3 (road A) wins.
    function automatic logic [1:0] top_bit(input logic [SND_W-1:0] v);
        top_bit = 2'd0;
        for (int i = 0; i < int'(SND_W); i++) begin
            if (v[i]) top_bit = 2'(i);
        end
    endfunction

    function automatic logic [SND_W-1:0] one_hot(input logic [1:0] c);
        one_hot = SND_W'(1) << c;
    endfunction

    function automatic logic [1:0] pop3(input logic [2:0] b);
        pop3 = {1'b0, b[0]} + {1'b0, b[1]} + {1'b0, b[2]};
    endfunction

    // Per-bit debounce: output follows the synced input only after a full stable run.
    always_comb begin
        ir_d = ir_q;
        for (int i = 0; i < int'(IR_W); i++) begin
            db_cnt_d[i] = '0;
            if (s_ir_q[i] != ir_q[i]) begin
                if (db_cnt_q[i] + CNT_W'(1) == DEB_LIM) begin
                    ir_d[i] = s_ir_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
                end
            end
        end
        density_d = {pop3(ir_q[11:9]), pop3(ir_q[8:6]), pop3(ir_q[5:3]), pop3(ir_q[2:0])};
    end

    // Siren FSM: confirm, latch, hold after drop; only IDLE/CONFIRM may change channel.
    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        snd_cnt_d = snd_cnt_q;
        snd_d     = snd_q;
        emerg_d   = |snd_q;
        unique case (state_q)
            S_IDLE: begin
                snd_d = '0;
                if (s_snd_q != '0) begin
                    cand_d    = top_bit(s_snd_q);
                    snd_cnt_d = CNT_W'(1);
                    if (CONF_LIM == CNT_W'(1)) begin
                        state_d   = S_ACTIVE;
                        snd_cnt_d = '0;
                        snd_d     = one_hot(top_bit(s_snd_q));
                    end else begin
                        state_d = S_CONFIRM;
                    end
                end
            end
            S_CONFIRM: begin
                if (s_snd_q != '0 && top_bit(s_snd_q) > cand_q) begin
                    cand_d    = top_bit(s_snd_q);
                    snd_cnt_d = CNT_W'(1);
                end else if (s_snd_q[cand_q]) begin
                    if (snd_cnt_q + CNT_W'(1) == CONF_LIM) begin
                        state_d   = S_ACTIVE;
                        snd_cnt_d = '0;
                        snd_d     = one_hot(cand_q);
                    end else begin
                        snd_cnt_d = snd_cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d   = S_IDLE;
                    snd_cnt_d = '0;
                end
            end
            S_ACTIVE: begin
                snd_d = one_hot(cand_q);
                if (!s_snd_q[cand_q]) begin
                    if (HOLD_LIM == CNT_W'(1)) begin
                        state_d   = S_IDLE;
                        snd_cnt_d = '0;
                        snd_d     = '0;
                    end else begin
                        state_d   = S_HOLD;
                        snd_cnt_d = CNT_W'(1);
                    end
                end
            end
            S_HOLD: begin
                if (s_snd_q[cand_q]) begin
                    state_d   = S_ACTIVE;
                    snd_cnt_d = '0;
                end else if (snd_cnt_q + CNT_W'(1) == HOLD_LIM) begin
                    state_d   = S_IDLE;
                    snd_cnt_d = '0;
                    snd_d     = '0;
                end else begin
                    snd_cnt_d = snd_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = S_IDLE;
                snd_cnt_d = '0;
                snd_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_meta_q  <= '0;
            s_ir_q     <= '0;
            snd_meta_q <= '0;
            s_snd_q    <= '0;
            ir_q       <= '0;
            for (int i = 0; i < int'(IR_W); i++) db_cnt_q[i] <= '0;
            density_q  <= '0;
            state_q    <= S_IDLE;
            cand_q     <= '0;
            snd_cnt_q  <= '0;
            snd_q      <= '0;
            emerg_q    <= 1'b0;
        end else begin
            ir_meta_q  <= raw_ir;
            s_ir_q     <= ir_meta_q;
            snd_meta_q <= raw_sound;
            s_snd_q    <= snd_meta_q;
            ir_q       <= ir_d;
            for (int i = 0; i < int'(IR_W); i++) db_cnt_q[i] <= db_cnt_d[i];
            density_q  <= density_d;
            state_q    <= state_d;
            cand_q     <= cand_d;
            snd_cnt_q  <= snd_cnt_d;
            snd_q      <= snd_d;
            emerg_q    <= emerg_d;
        end
    end

    assign IR_sensors       = ir_q;
    assign sound_sensors    = snd_q;
    assign density          = density_q;
    assign emergency_active = emerg_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Scoreboard bench for sensor_conditioner: expectations are queued against absolute edge
// numbers as stimulus is driven and compared on the falling edge of that cycle.
module tb_sensor_conditioner;

    localparam int SEL_IR  = 0;
    localparam int SEL_SND = 1;
    localparam int SEL_DEN = 2;
    localparam int SEL_EMG = 3;

    logic        clk;
    logic        rst_n;
    logic [11:0] raw_ir;
    logic [3:0]  raw_sound;
    logic [11:0] IR_sensors;
    logic [3:0]  sound_sensors;
    logic [7:0]  density;
    logic        emergency_active;

    sensor_conditioner dut (
        .clk              (clk),
        .reset            (rst_n),
        .raw_ir           (raw_ir),
        .raw_sound        (raw_sound),
        .IR_sensors       (IR_sensors),
        .sound_sensors    (sound_sensors),
        .density          (density),
        .emergency_active (emergency_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        int          sel;
        logic [11:0] val;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc;
    int          n_cmp;
    int          n_err;

    task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [11:0] observe(input int sel);
        case (sel)
            SEL_IR:  observe = IR_sensors;
            SEL_SND: observe = 12'(sound_sensors);
            SEL_DEN: observe = 12'(density);
            default: observe = 12'(emergency_active);
        endcase
    endfunction

    task automatic expect_at(input int unsigned c, input int sel, input logic [11:0] v,
                             input string tag);
        exp_t e;
        e.cyc = c;
        e.sel = sel;
        e.val = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic expect_range(input int unsigned c0, input int unsigned c1, input int sel,
                                input logic [11:0] v, input string tag);
        for (int unsigned c = c0; c <= c1; c++) expect_at(c, sel, v, tag);
    endtask

    task automatic check_due();
        for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                check_eq(sb[i].tag, observe(sb[i].sel), sb[i].val);
                sb.delete(i);
            end
        end
    endtask

    // One edge: count it, then compare everything due for it away from the edge.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            check_due();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ir"},  IR_sensors, 12'h000);
        check_eq({tag, "_snd"}, 12'(sound_sensors), 12'h000);
        check_eq({tag, "_den"}, 12'(density), 12'h000);
        check_eq({tag, "_emg"}, 12'(emergency_active), 12'h000);
    endtask

    // Asynchronous reset asserted mid-cycle; released on a falling edge.
    task automatic reset_pulse(input string tag);
        #2 rst_n = 1'b0;
        #1 check_all_zero(tag);
        step(2);
        rst_n = 1'b1;
    endtask

    int unsigned t;

    initial begin
        cyc       = 0;
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        raw_ir    = '0;
        raw_sound = '0;
        step(2);
        check_all_zero("por");

        // Reset test: all sensors asserted.
        rst_n     = 1'b1;
        raw_ir    = 12'hFFF;
        raw_sound = 4'hF;
        t = cyc;
        expect_at(t + 5, SEL_IR, 12'h000, "ir_pre");
        expect_at(t + 6, SEL_IR, 12'hFFF, "ir_all");
        expect_at(t + 6, SEL_DEN, 12'h000, "den_pre");
        expect_at(t + 7, SEL_DEN, 12'h0FF, "den_all");
        expect_at(t + 9, SEL_SND, 12'h000, "snd_pre");
        expect_at(t + 10, SEL_SND, 12'h008, "snd_prio_a");
        expect_at(t + 10, SEL_EMG, 12'h000, "emg_pre");
        expect_at(t + 11, SEL_EMG, 12'h001, "emg_on");
        step(14);
        reset_pulse("midrun");
        t = cyc;
        expect_at(t + 5, SEL_IR, 12'h000, "rst_ir_pre");
        expect_at(t + 6, SEL_IR, 12'hFFF, "rst_ir6");
        expect_at(t + 7, SEL_DEN, 12'h0FF, "rst_den7");
        expect_at(t + 10, SEL_SND, 12'h008, "rst_snd10");
        step(12);
        raw_ir    = '0;
        raw_sound = '0;
        reset_pulse("clean");
        step(3);

        // Glitch rejection: 3-cycle pulse ignored, 4-cycle pulse accepted.
        t = cyc;
        raw_ir = 12'h020;
        expect_range(t + 1, t + 12, SEL_IR, 12'h000, "glitch3");
        step(3);
        raw_ir = 12'h000;
        step(10);
        t = cyc;
        raw_ir = 12'h020;
        expect_at(t + 5, SEL_IR, 12'h000, "deb4_pre");
        expect_at(t + 6, SEL_IR, 12'h020, "deb4_ir");
        expect_at(t + 6, SEL_DEN, 12'h000, "deb4_den_pre");
        expect_at(t + 7, SEL_DEN, 12'h004, "deb4_den");
        expect_at(t + 9, SEL_IR, 12'h020, "deb4_keep");
        expect_at(t + 10, SEL_IR, 12'h000, "deb4_fall");
        expect_at(t + 11, SEL_DEN, 12'h000, "deb4_den_fall");
        step(4);
        raw_ir = 12'h000;
        step(10);

        // Confirm on D, then no preemption by A, then release.
        t = cyc;
        raw_sound = 4'b0001;
        expect_at(t + 9, SEL_SND, 12'h000, "conf_pre");
        expect_at(t + 10, SEL_SND, 12'h001, "conf_d");
        expect_at(t + 10, SEL_EMG, 12'h000, "conf_emg_pre");
        expect_at(t + 11, SEL_EMG, 12'h001, "conf_emg");
        step(12);
        raw_sound = 4'b1001;
        expect_range(t + 13, t + 30, SEL_SND, 12'h001, "no_preempt");
        step(18);
        t = cyc;
        raw_sound = 4'b0000;
        expect_at(t + 33, SEL_SND, 12'h001, "rel_pre");
        expect_at(t + 34, SEL_SND, 12'h000, "rel_clr");
        expect_at(t + 34, SEL_EMG, 12'h001, "rel_emg_lag");
        expect_at(t + 35, SEL_EMG, 12'h000, "rel_emg_clr");
        step(38);

        // Restart on higher priority during confirm.
        t = cyc;
        raw_sound = 4'b0010;
        expect_range(t + 1, t + 14, SEL_SND, 12'h000, "restart_quiet");
        expect_range(t + 15, t + 20, SEL_SND, 12'h008, "restart_a");
        step(5);
        raw_sound = 4'b1010;
        step(15);

        // Hold and re-trigger on A; B stays present throughout.
        t = cyc;
        raw_sound = 4'b0010;
        expect_range(t + 1, t + 30, SEL_SND, 12'h008, "hold_keep");
        step(20);
        raw_sound = 4'b1010;
        step(10);
        t = cyc;
        raw_sound = 4'b0010;
        expect_at(t + 33, SEL_SND, 12'h008, "hold_pre");
        expect_at(t + 34, SEL_SND, 12'h000, "hold_clr");
        expect_at(t + 35, SEL_EMG, 12'h000, "hold_emg_clr");
        expect_range(t + 35, t + 41, SEL_SND, 12'h000, "reeval_quiet");
        expect_at(t + 42, SEL_SND, 12'h002, "reeval_b");
        step(44);
        t = cyc;
        raw_sound = 4'b0000;
        expect_at(t + 34, SEL_SND, 12'h000, "b_clr");
        step(36);

        // Short siren (7) rejected; 8 cycles is the shortest accepted.
        t = cyc;
        raw_sound = 4'b0100;
        expect_range(t + 1, t + 20, SEL_SND, 12'h000, "short7");
        step(7);
        raw_sound = 4'b0000;
        step(13);
        t = cyc;
        raw_sound = 4'b0100;
        expect_at(t + 9, SEL_SND, 12'h000, "edge8_pre");
        expect_at(t + 10, SEL_SND, 12'h004, "edge8_c");
        expect_at(t + 41, SEL_SND, 12'h004, "edge8_hold");
        expect_at(t + 42, SEL_SND, 12'h000, "edge8_clr");
        step(8);
        raw_sound = 4'b0000;
        step(36);

        for (int k = 0; k < 100 && sb.size() != 0; k++) step(1);
        check_eq("drain", 12'(sb.size()), 12'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
